// File: rtl/disp_page_seq.sv
// Registered page selector for an N-digit seven-segment bus: static pages plus
// a marquee scroll and a blinking view of the score, sharing one divider.
module disp_page_seq #(
    parameter int unsigned     NUM_DIGITS = 6,
    parameter int unsigned     SEG_W      = 8,
    parameter logic [SEG_W-1:0] DASH_CODE  = 8'h3F,
    parameter logic [SEG_W-1:0] BLANK_CODE = 8'h7F,
    parameter int unsigned     SCROLL_DIV = 25000000,
    parameter int unsigned     BLINK_DIV  = 12500000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  mode,
    input  logic [SEG_W-1:0]            mode_disp,
    input  logic [NUM_DIGITS*SEG_W-1:0] scram_bus,
    input  logic [NUM_DIGITS*SEG_W-1:0] score_bus,
    output logic [NUM_DIGITS*SEG_W-1:0] disp_bus,
    output logic                        scroll_wrap,
    output logic                        blink_phase
);

    localparam int unsigned DIV_MAX = (SCROLL_DIV > BLINK_DIV) ? SCROLL_DIV : BLINK_DIV;
    localparam int unsigned CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int unsigned V_LEN   = 2 * NUM_DIGITS;
    localparam int unsigned P_W     = $clog2(V_LEN);

    localparam logic [2:0] ModeGlyph  = 3'd1;
    localparam logic [2:0] ModeScram  = 3'd2;
    localparam logic [2:0] ModeScore  = 3'd3;
    localparam logic [2:0] ModeScroll = 3'd4;
    localparam logic [2:0] ModeBlink  = 3'd5;

    logic [2:0]                  mode_q;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [P_W-1:0]              p_q, p_d;
    logic                        phase_q, phase_d;
    logic                        wrap_q, wrap_d;
    logic [NUM_DIGITS*SEG_W-1:0] disp_q, disp_d;

    // Divider and position/phase state; everything falls back to 0 on mode entry
    // and in the static modes.
    always_comb begin
        cnt_d   = '0;
        p_d     = '0;
        phase_d = 1'b0;
        wrap_d  = 1'b0;
        if (mode == mode_q) begin
            if (mode == ModeScroll) begin
                p_d = p_q;
                if (cnt_q == CNT_W'(SCROLL_DIV - 1)) begin
                    if (p_q == P_W'(V_LEN - 1)) begin
                        p_d    = '0;
                        wrap_d = 1'b1;
                    end else begin
                        p_d = p_q + P_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (mode == ModeBlink) begin
                phase_d = phase_q;
                if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        int unsigned idx;
        disp_d = {NUM_DIGITS{DASH_CODE}};
        idx    = 0;
        unique case (mode)
            ModeGlyph:  disp_d[SEG_W-1:0] = mode_disp;
            ModeScram:  disp_d = scram_bus;
            ModeScore:  disp_d = score_bus;
            ModeScroll: begin
                // Virtual string: score digits followed by N dashes.
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    idx = (i + 32'(p_d)) % V_LEN;
                    if (idx < NUM_DIGITS) begin
                        disp_d[i*SEG_W +: SEG_W] = score_bus[idx*SEG_W +: SEG_W];
                    end
                end
            end
            ModeBlink:  disp_d = phase_d ? {NUM_DIGITS{BLANK_CODE}} : score_bus;
            default:    disp_d = {NUM_DIGITS{DASH_CODE}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            phase_q <= 1'b0;
            wrap_q  <= 1'b0;
            disp_q  <= {NUM_DIGITS{DASH_CODE}};
        end else begin
            mode_q  <= mode;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            disp_q  <= disp_d;
        end
    end

    assign disp_bus    = disp_q;
    assign scroll_wrap = wrap_q;
    assign blink_phase = phase_q;

endmodule
